// File: rtl/deu_gpr_wb.sv
// deu_gpr_wb: GPR write-back arbiter.
// Collects results from NSRC execution sources (0=ALU0, 1=ALU1, 2=MULDIV, 3=LSU).
// Each source has its own 2-entry queue. Each cycle, up to three queue heads are
// granted onto three registered GPR write ports.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   src_valid/src_ready  per-source handshake; a transfer happens when both are high at an edge
//   src_addr/src_data    per-source destination GPR index and result value
//   we0..2               registered GPR write enables
//   waddr0..2, wd0..2    registered GPR write addresses and data
//   wb_idle              all queues empty and no write enable asserted
module deu_gpr_wb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NSRC   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NSRC-1:0]               src_valid,
  output logic [NSRC-1:0]               src_ready,
  input  logic [NSRC-1:0][ADDR_W-1:0]   src_addr,
  input  logic [NSRC-1:0][DATA_W-1:0]   src_data,
  output logic                          we0,
  output logic                          we1,
  output logic                          we2,
  output logic [ADDR_W-1:0]             waddr0,
  output logic [ADDR_W-1:0]             waddr1,
  output logic [ADDR_W-1:0]             waddr2,
  output logic [DATA_W-1:0]             wd0,
  output logic [DATA_W-1:0]             wd1,
  output logic [DATA_W-1:0]             wd2,
  output logic                          wb_idle
);

  localparam int unsigned PtrW   = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned NPorts = 3;

  // Per-source 2-entry queues
  logic [ADDR_W-1:0] mem_addr_q [NSRC][2];
  logic [DATA_W-1:0] mem_data_q [NSRC][2];
  logic              rd_q       [NSRC];
  logic              wr_q       [NSRC];
  logic [1:0]        cnt_q      [NSRC];

  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic [ADDR_W-1:0] head_addr  [NSRC];
  logic [DATA_W-1:0] head_data  [NSRC];
  logic [NSRC-1:0]   head_valid;

  logic [PtrW-1:0]   rr_q, rr_d;

  // Grant slots, filled in scan order
  logic              gnt_v [NPorts];
  logic [ADDR_W-1:0] gnt_a [NPorts];
  logic [DATA_W-1:0] gnt_d [NPorts];

  // Registered write ports
  logic              we_q    [NPorts];
  logic [ADDR_W-1:0] waddr_q [NPorts];
  logic [DATA_W-1:0] wd_q    [NPorts];

  // Ready depends on registered occupancy only, so there is no path from src_valid.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i]  = (cnt_q[i] != 2'd2);
      push[i]       = src_valid[i] & src_ready[i];
      head_valid[i] = (cnt_q[i] != 2'd0);
      head_addr[i]  = mem_addr_q[i][rd_q[i]];
      head_data[i]  = mem_data_q[i][rd_q[i]];
    end
  end

  // Round-robin scan from rr_q. Addr-0 heads are discarded without using a port.
  // Heads whose address matches an earlier grant this cycle wait, so no two ports
  // ever share a write address. Scanning stops once all ports are taken.
  always_comb begin
    logic [PtrW-1:0] idx;
    logic [1:0]      nport;
    logic            full;
    logic            conflict;
    pop      = '0;
    rr_d     = rr_q;
    idx      = '0;
    nport    = '0;
    full     = 1'b0;
    conflict = 1'b0;
    for (int p = 0; p < NPorts; p++) begin
      gnt_v[p] = 1'b0;
      gnt_a[p] = '0;
      gnt_d[p] = '0;
    end
    for (int k = 0; k < NSRC; k++) begin
      idx = PtrW'((int'(rr_q) + k) % int'(NSRC));
      if (!full && head_valid[idx]) begin
        if (head_addr[idx] == '0) begin
          pop[idx] = 1'b1;
          rr_d     = PtrW'((int'(idx) + 1) % int'(NSRC));
        end else begin
          conflict = 1'b0;
          for (int j = 0; j < NPorts; j++) begin
            if (gnt_v[j] && (gnt_a[j] == head_addr[idx])) conflict = 1'b1;
          end
          if (!conflict) begin
            gnt_v[nport] = 1'b1;
            gnt_a[nport] = head_addr[idx];
            gnt_d[nport] = head_data[idx];
            pop[idx]     = 1'b1;
            rr_d         = PtrW'((int'(idx) + 1) % int'(NSRC));
            if (nport == 2'd2) full = 1'b1;
            else               nport = nport + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        for (int e = 0; e < 2; e++) begin
          mem_addr_q[i][e] <= '0;
          mem_data_q[i][e] <= '0;
        end
        rd_q[i]  <= 1'b0;
        wr_q[i]  <= 1'b0;
        cnt_q[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) begin
          mem_addr_q[i][wr_q[i]] <= src_addr[i];
          mem_data_q[i][wr_q[i]] <= src_data[i];
          wr_q[i]                <= ~wr_q[i];
        end
        if (pop[i]) rd_q[i] <= ~rd_q[i];
        unique case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 2'd1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 2'd1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      for (int p = 0; p < NPorts; p++) begin
        we_q[p]    <= 1'b0;
        waddr_q[p] <= '0;
        wd_q[p]    <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int p = 0; p < NPorts; p++) begin
        we_q[p]    <= gnt_v[p];
        waddr_q[p] <= gnt_a[p];
        wd_q[p]    <= gnt_d[p];
      end
    end
  end

  assign we0    = we_q[0];
  assign we1    = we_q[1];
  assign we2    = we_q[2];
  assign waddr0 = waddr_q[0];
  assign waddr1 = waddr_q[1];
  assign waddr2 = waddr_q[2];
  assign wd0    = wd_q[0];
  assign wd1    = wd_q[1];
  assign wd2    = wd_q[2];

  always_comb begin
    wb_idle = ~(we_q[0] | we_q[1] | we_q[2]);
    for (int i = 0; i < NSRC; i++) begin
      if (cnt_q[i] != 2'd0) wb_idle = 1'b0;
    end
  end

endmodule
